// File: rtl/frog_life_tracker.sv
// frog_life_tracker: game-progress controller downstream of the frog movement block.
// Tracks score, lives and game phase (idle, respawn, play, dying, goal, over),
// and drives frog_reset so the frog block respawns at its start cell.
//
// Ports:
//   frame_clk    in   1   frame clock, one tick per video frame
//   Reset        in   1   asynchronous active-low reset
//   FrogX        in  11   frog X position (debug only, unused here)
//   FrogY        in  11   frog Y position, unsigned
//   hazard_hit   in   1   frog overlaps a car or water this frame
//   start        in   1   level input, starts/restarts the game
//   frog_reset   out  1   active-high reset to the frog block
//   frog_visible out  1   sprite enable for the renderer
//   lives        out  3   remaining lives
//   score        out 16   accumulated score, saturating at 16'hFFFF
//   playing      out  1   high in PLAY
//   game_over    out  1   high in OVER
module frog_life_tracker #(
  parameter int unsigned FROG_Y_START = 440,
  parameter int unsigned GOAL_Y       = 0,
  parameter int unsigned Y_VALID_MAX  = 440,
  parameter int unsigned NUM_LIVES    = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned GOAL_FRAMES  = 30,
  parameter int unsigned ROW_POINTS   = 10,
  parameter int unsigned GOAL_POINTS  = 50
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [10:0] FrogX,
  input  logic [10:0] FrogY,
  input  logic        hazard_hit,
  input  logic        start,
  output logic        frog_reset,
  output logic        frog_visible,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic        playing,
  output logic        game_over
);

  localparam int unsigned YW = 11;
  localparam int unsigned SW = 16;
  localparam int unsigned TW = 8;
  localparam int unsigned LW = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESPAWN = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_DYING   = 3'd3;
  localparam logic [2:0] ST_GOAL    = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [YW-1:0] best_q, best_d;
  logic          frog_reset_q, frog_reset_d;
  logic          visible_q, visible_d;
  logic          playing_q, playing_d;
  logic          over_q, over_d;

  logic [SW-1:0] add_pts;
  logic [SW:0]   sum;

  // FrogX is carried for debug only
  logic unused_frogx;
  assign unused_frogx = ^FrogX;

  // Next-state, scoring and registered-output decode
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    timer_d = timer_q;
    best_d  = best_q;
    add_pts = '0;
    sum     = '0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_d = '0;
          lives_d = LW'(NUM_LIVES);
          state_d = ST_RESPAWN;
        end
      end
      ST_RESPAWN: begin
        best_d  = YW'(FROG_Y_START);
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Goal beats a simultaneous hit; a hit frame awards no row points
        if (FrogY == YW'(GOAL_Y)) begin
          add_pts = SW'(GOAL_POINTS);
          timer_d = TW'(GOAL_FRAMES - 1);
          state_d = ST_GOAL;
        end else if (hazard_hit) begin
          lives_d = lives_q - LW'(1);
          timer_d = TW'(DEATH_FRAMES - 1);
          state_d = ST_DYING;
        end else if ((FrogY < best_q) && (FrogY <= YW'(Y_VALID_MAX))) begin
          add_pts = SW'(ROW_POINTS);
          best_d  = FrogY;
        end
      end
      ST_DYING: begin
        if (timer_q == '0) begin
          state_d = (lives_q == '0) ? ST_OVER : ST_RESPAWN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_GOAL: begin
        if (timer_q == '0) begin
          state_d = ST_RESPAWN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturating score add
    if (add_pts != '0) begin
      sum     = (SW+1)'(score_q) + (SW+1)'(add_pts);
      score_d = sum[SW] ? {SW{1'b1}} : sum[SW-1:0];
    end

    // Outputs decoded from the next state so they align with the state register
    frog_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESPAWN) || (state_d == ST_OVER);
    visible_d    = (state_d != ST_DYING) || timer_d[3];
    playing_d    = (state_d == ST_PLAY);
    over_d       = (state_d == ST_OVER);
  end

  // State, counters and output registers
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      lives_q      <= '0;
      timer_q      <= '0;
      best_q       <= YW'(FROG_Y_START);
      frog_reset_q <= 1'b1;
      visible_q    <= 1'b1;
      playing_q    <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      timer_q      <= timer_d;
      best_q       <= best_d;
      frog_reset_q <= frog_reset_d;
      visible_q    <= visible_d;
      playing_q    <= playing_d;
      over_q       <= over_d;
    end
  end

  assign frog_reset   = frog_reset_q;
  assign frog_visible = visible_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign playing      = playing_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_frog_life_tracker.sv
// Testbench for frog_life_tracker: directed game scenarios plus random frames,
// every frame compared against a phase-level reference model of the game rules.
module tb_frog_life_tracker;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [10:0] FrogX = '0;
  logic [10:0] FrogY = 11'd440;
  logic        hazard_hit = 1'b0;
  logic        start = 1'b0;
  logic        frog_reset, frog_visible, playing, game_over;
  logic [2:0]  lives;
  logic [15:0] score;

  frog_life_tracker dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .FrogX        (FrogX),
    .FrogY        (FrogY),
    .hazard_hit   (hazard_hit),
    .start        (start),
    .frog_reset   (frog_reset),
    .frog_visible (frog_visible),
    .lives        (lives),
    .score        (score),
    .playing      (playing),
    .game_over    (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  localparam int P_IDLE = 0, P_RESPAWN = 1, P_PLAY = 2, P_DYING = 3, P_GOAL = 4, P_OVER = 5;

  int m_phase, m_score, m_lives, m_timer, m_best;
  int n_checks = 0;
  int n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_score = 0; m_lives = 0; m_timer = 0; m_best = 440;
  endtask

  function automatic int add_sat(input int s, input int p);
    return (s + p > 65535) ? 65535 : s + p;
  endfunction

  // One frame of the game rules, applied with the inputs seen at the next edge
  task automatic model_step(input int y, input bit hit, input bit st);
    case (m_phase)
      P_IDLE, P_OVER:
        if (st) begin m_score = 0; m_lives = 3; m_phase = P_RESPAWN; end
      P_RESPAWN: begin m_best = 440; m_phase = P_PLAY; end
      P_PLAY:
        if (y == 0) begin
          m_score = add_sat(m_score, 50); m_timer = 29; m_phase = P_GOAL;
        end else if (hit) begin
          m_lives = m_lives - 1; m_timer = 59; m_phase = P_DYING;
        end else if (y < m_best && y <= 440) begin
          m_score = add_sat(m_score, 10); m_best = y;
        end
      P_DYING:
        if (m_timer == 0) m_phase = (m_lives == 0) ? P_OVER : P_RESPAWN;
        else m_timer = m_timer - 1;
      P_GOAL:
        if (m_timer == 0) m_phase = P_RESPAWN;
        else m_timer = m_timer - 1;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("frog_reset", 32'(frog_reset),
          32'(m_phase == P_IDLE || m_phase == P_RESPAWN || m_phase == P_OVER));
    check("frog_visible", 32'(frog_visible),
          32'(m_phase != P_DYING || ((m_timer / 8) % 2 == 1)));
    check("playing", 32'(playing), 32'(m_phase == P_PLAY));
    check("game_over", 32'(game_over), 32'(m_phase == P_OVER));
    check("lives", 32'(lives), 32'(m_lives));
    check("score", 32'(score), 32'(m_score));
  endtask

  // Called at a falling edge: check, drive the frame's inputs, advance one frame
  task automatic frame(input int y, input bit hit, input bit st);
    check_outputs();
    FrogY = 11'(y);
    FrogX = 11'($urandom_range(0, 639));
    hazard_hit = hit;
    start = st;
    model_step(y, hit, st);
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  // Step until the model is in PLAY, pressing start when idle or over
  task automatic to_play();
    for (int i = 0; i < 200 && m_phase != P_PLAY; i++)
      frame(440, 1'b0, (m_phase == P_IDLE || m_phase == P_OVER));
  endtask

  // Ride out a DYING or GOAL phase; returns its length in frames
  task automatic wait_phase(output int n);
    n = 0;
    while (frog_reset == 1'b0 && playing == 1'b0 && n < 100) begin
      n++;
      frame(360, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  int n;
  int y;
  int rounds;

  initial begin
    model_reset();
    @(negedge frame_clk);
    check("rst_frog_reset", 32'(frog_reset), 32'd1);
    check("rst_playing", 32'(playing), 32'd0);
    Reset = 1'b1;

    // Game start: IDLE -> RESPAWN (1 frame) -> PLAY
    frame(440, 1'b0, 1'b1);
    check("respawn_frog_reset", 32'(frog_reset), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    frame(440, 1'b0, 1'b0);
    check("play_entered", 32'(playing), 32'd1);

    // Row scoring: up, up, down, up again, new best
    frame(400, 1'b0, 1'b1); check("row_1", 32'(score), 32'd10);
    frame(360, 1'b0, 1'b0); check("row_2", 32'(score), 32'd20);
    frame(400, 1'b0, 1'b0); check("row_back", 32'(score), 32'd20);
    frame(360, 1'b0, 1'b0); check("row_revisit", 32'(score), 32'd20);
    frame(320, 1'b0, 1'b0); check("row_3", 32'(score), 32'd30);
    frame(330, 1'b0, 1'b0); check("row_below_best", 32'(score), 32'd30);
    frame(900, 1'b0, 1'b0); check("row_underflow", 32'(score), 32'd30);

    // Hit: lose a life, 60 DYING frames, one RESPAWN frame, best_y reset
    frame(360, 1'b1, 1'b0);
    check("hit_lives", 32'(lives), 32'd2);
    check("hit_score", 32'(score), 32'd30);
    wait_phase(n);
    check("dying_len", 32'(n), 32'd60);
    check("after_dying_reset", 32'(frog_reset), 32'd1);
    frame(440, 1'b0, 1'b0);
    frame(400, 1'b0, 1'b0);
    check("best_reset", 32'(score), 32'd40);

    // Two more hits: game over with score held
    frame(360, 1'b1, 1'b0); wait_phase(n);
    frame(440, 1'b0, 1'b0);
    frame(360, 1'b1, 1'b0); wait_phase(n);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_lives", 32'(lives), 32'd0);
    check("over_score", 32'(score), 32'd40);
    frame(440, 1'b0, 1'b0); frame(440, 1'b0, 1'b0);
    check("over_hold", 32'(score), 32'd40);
    frame(440, 1'b0, 1'b1);
    check("restart_score", 32'(score), 32'd0);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_respawn", 32'(frog_reset), 32'd1);

    // Goal and hit together count as the goal
    to_play();
    frame(0, 1'b1, 1'b0);
    check("goal_score", 32'(score), 32'd50);
    check("goal_lives", 32'(lives), 32'd3);
    wait_phase(n);
    check("goal_len", 32'(n), 32'd30);
    check("after_goal_reset", 32'(frog_reset), 32'd1);

    // Random play, start held at random times
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) y = 0;
      else if ($urandom_range(0, 7) == 0) y = $urandom_range(800, 1023);
      else if ($urandom_range(0, 1) == 0) y = 40 * $urandom_range(1, 11);
      else y = $urandom_range(1, 440);
      frame(y, ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0));
    end

    // Climb and score goals repeatedly until the score saturates
    rounds = 0;
    while (m_score < 65535 && rounds < 600) begin
      to_play();
      for (int r = 400; r >= 40; r -= 40) frame(r, 1'b0, 1'b0);
      frame(0, 1'b0, 1'b0);
      rounds++;
    end
    check("sat_score", 32'(score), 32'hFFFF);
    to_play();
    frame(0, 1'b0, 1'b0);
    check("sat_hold", 32'(score), 32'hFFFF);

    // Asynchronous reset in the middle of DYING
    to_play();
    frame(200, 1'b1, 1'b0);
    frame(200, 1'b0, 1'b0);
    frame(200, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    check("arst_frog_reset", 32'(frog_reset), 32'd1);
    check("arst_visible", 32'(frog_visible), 32'd1);
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_over", 32'(game_over), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_lives", 32'(lives), 32'd0);
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    frame(440, 1'b0, 1'b0);
    frame(440, 1'b0, 1'b1);
    frame(440, 1'b0, 1'b0);
    frame(400, 1'b0, 1'b0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
